// File: rtl/cdr_phase_ctrl.sv
// Phase-selection controller for a 4-phase oversampling CDR front end.
// Picks the phase farthest from the dominant edge, with hysteresis, lock and LOS reporting.
module cdr_phase_ctrl #(
    parameter int WINDOW         = 64,
    parameter int SWITCH_WINDOWS = 2,
    parameter int LOCK_WINDOWS   = 4,
    parameter int LOS_WINDOWS    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       valid,
    input  logic [3:0] edge_flags,
    input  logic [3:0] samples,
    output logic [1:0] sel_phase,
    output logic       locked,
    output logic       los,
    output logic       phase_changed,
    output logic       data_out,
    output logic       data_valid
);

    localparam int CW = $clog2(WINDOW + 1);
    localparam int SW = $clog2(SWITCH_WINDOWS + 1);
    localparam int LW = $clog2(LOCK_WINDOWS + 1);
    localparam int ZW = $clog2(LOS_WINDOWS + 1);
    localparam logic [CW-1:0] WEND   = CW'(WINDOW - 1);
    localparam logic [SW-1:0] SW_MAX = SW'(SWITCH_WINDOWS);
    localparam logic [LW-1:0] L_MAX  = LW'(LOCK_WINDOWS);
    localparam logic [ZW-1:0] Z_MAX  = ZW'(LOS_WINDOWS);

    typedef enum logic {ACQ = 1'b0, LOCK = 1'b1} state_t;

    logic [3:0][CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CW-1:0]      wcnt_q, wcnt_d;
    state_t             state_q, state_d;
    logic [1:0]         sel_q, sel_d, pend_phase_q, pend_phase_d;
    logic [SW-1:0]      pend_cnt_q, pend_cnt_d;
    logic [LW-1:0]      lock_cnt_q, lock_cnt_d;
    logic [ZW-1:0]      zero_cnt_q, zero_cnt_d;
    logic               locked_q, locked_d, los_q, los_d, pc_q, pc_d;
    logic               dout_q, dout_d, dvalid_q, dvalid_d;
    logic               win_end, all_zero;
    logic [1:0]         win_idx, target;
    logic [CW-1:0]      win_cnt;

    assign win_end = valid && (wcnt_q == WEND);
    assign wcnt_d  = (win_end || !enable) ? '0 : wcnt_q + CW'(valid);

    // Counts include the current cycle so the window-end decision sees every sample.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
            assign cnt_inc[gi] = cnt_q[gi] + CW'(valid && edge_flags[gi]);
            assign cnt_d[gi]   = (win_end || !enable) ? '0 : cnt_inc[gi];
        end
    endgenerate

    always_comb begin
        win_idx = '0;
        win_cnt = cnt_inc[0];
        for (int i = 1; i < 4; i++) begin
            if (cnt_inc[i] > win_cnt) begin
                win_cnt = cnt_inc[i];
                win_idx = 2'(i);
            end
        end
        all_zero = (cnt_inc == '0);
        target   = win_idx + 2'd2;
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        pend_phase_d = pend_phase_q;
        pend_cnt_d   = pend_cnt_q;
        lock_cnt_d   = lock_cnt_q;
        zero_cnt_d   = zero_cnt_q;
        los_d        = los_q;
        pc_d         = 1'b0;
        dvalid_d     = valid;
        dout_d       = valid ? samples[sel_q] : dout_q;

        if (win_end) begin
            if (all_zero) begin
                if (zero_cnt_q != Z_MAX) zero_cnt_d = zero_cnt_q + 1'b1;
                if (zero_cnt_d == Z_MAX) begin
                    los_d      = 1'b1;
                    lock_cnt_d = '0;
                    state_d    = ACQ;
                end
            end else begin
                zero_cnt_d = '0;
                los_d      = 1'b0;
                if (target == sel_q) begin
                    pend_cnt_d = '0;
                    if (lock_cnt_q != L_MAX) lock_cnt_d = lock_cnt_q + 1'b1;
                    if (lock_cnt_d == L_MAX) state_d = LOCK;
                end else begin
                    // A pending candidate only accumulates while it stays unbroken.
                    if (target == pend_phase_q && pend_cnt_q != '0) begin
                        pend_cnt_d = pend_cnt_q + 1'b1;
                    end else begin
                        pend_phase_d = target;
                        pend_cnt_d   = SW'(1);
                    end
                    if (pend_cnt_d == SW_MAX) begin
                        sel_d      = target;
                        pend_cnt_d = '0;
                        lock_cnt_d = '0;
                        state_d    = ACQ;
                        pc_d       = 1'b1;
                    end
                end
            end
        end

        if (!enable) begin
            state_d      = ACQ;
            sel_d        = '0;
            pend_phase_d = '0;
            pend_cnt_d   = '0;
            lock_cnt_d   = '0;
            zero_cnt_d   = '0;
            los_d        = 1'b0;
            pc_d         = 1'b0;
            dvalid_d     = 1'b0;
            dout_d       = 1'b0;
        end
        locked_d = (state_d == LOCK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            wcnt_q       <= '0;
            state_q      <= ACQ;
            sel_q        <= '0;
            pend_phase_q <= '0;
            pend_cnt_q   <= '0;
            lock_cnt_q   <= '0;
            zero_cnt_q   <= '0;
            locked_q     <= 1'b0;
            los_q        <= 1'b0;
            pc_q         <= 1'b0;
            dout_q       <= 1'b0;
            dvalid_q     <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            wcnt_q       <= wcnt_d;
            state_q      <= state_d;
            sel_q        <= sel_d;
            pend_phase_q <= pend_phase_d;
            pend_cnt_q   <= pend_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
            zero_cnt_q   <= zero_cnt_d;
            locked_q     <= locked_d;
            los_q        <= los_d;
            pc_q         <= pc_d;
            dout_q       <= dout_d;
            dvalid_q     <= dvalid_d;
        end
    end

    assign sel_phase     = sel_q;
    assign locked        = locked_q;
    assign los           = los_q;
    assign phase_changed = pc_q;
    assign data_out      = dout_q;
    assign data_valid    = dvalid_q;

endmodule

// File: tb/tb_cdr_phase_ctrl.sv
// Scoreboard bench for cdr_phase_ctrl: stimulus queues expected data bits and phase events,
// a negedge monitor pops them whenever the DUT presents data_valid or phase_changed.
module tb_cdr_phase_ctrl;

    localparam int WINDOW = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       valid = 1'b0;
    logic [3:0] edge_flags = '0;
    logic [3:0] samples = '0;
    logic [1:0] sel_phase;
    logic       locked, los, phase_changed, data_out, data_valid;

    int total = 0;
    int bad = 0;
    logic       exp_data_q[$];
    logic [1:0] exp_phase_q[$];
    logic [1:0] exp_sel = 2'd0;

    cdr_phase_ctrl #(
        .WINDOW(WINDOW), .SWITCH_WINDOWS(2), .LOCK_WINDOWS(4), .LOS_WINDOWS(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .valid(valid),
        .edge_flags(edge_flags), .samples(samples), .sel_phase(sel_phase),
        .locked(locked), .los(los), .phase_changed(phase_changed),
        .data_out(data_out), .data_valid(data_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation each time the DUT presents an output event.
    always @(negedge clk) begin
        if (rst_n) begin
            if (data_valid) begin
                if (exp_data_q.size() == 0) check("data_valid_unexpected", int'(data_valid), 0);
                else check("data_out", int'(data_out), int'(exp_data_q.pop_front()));
            end
            if (phase_changed) begin
                if (exp_phase_q.size() == 0) begin
                    check("phase_changed_unexpected", int'(phase_changed), 0);
                end else begin
                    $display("phase event: sel_phase=%0d at %0t", sel_phase, $time);
                    check("phase_event_sel", int'(sel_phase), int'(exp_phase_q.pop_front()));
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [3:0] ef);
        logic [3:0] s;
        s          = 4'($urandom);
        valid      = v;
        edge_flags = ef;
        samples    = s;
        if (v) exp_data_q.push_back(s[exp_sel]);
        @(posedge clk);
        #1;
    endtask

    task automatic run_windows(input int n, input logic [3:0] ef);
        repeat (n * WINDOW) drive(1'b1, ef);
    endtask

    // Two idle cycles (carrying decoy edges) before each valid cycle.
    task automatic run_gapped(input int nv, input logic [3:0] ef, input logic [3:0] gap_ef);
        repeat (nv) begin
            drive(1'b0, gap_ef);
            drive(1'b0, gap_ef);
            drive(1'b1, ef);
        end
    endtask

    task automatic check_status(input string name, input int e_sel, input int e_locked, input int e_los);
        check({name, ".sel"}, int'(sel_phase), e_sel);
        check({name, ".locked"}, int'(locked), e_locked);
        check({name, ".los"}, int'(los), e_los);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at %0t, expected finish before", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_status("reset", 0, 0, 0);
        check("reset.data_valid", int'(data_valid), 0);
        check("reset.phase_changed", int'(phase_changed), 0);
        rst_n = 1'b1;

        // Edges on phase 0: switch to phase 2 after two windows, lock after four more.
        run_windows(1, 4'b0001);
        check_status("acq_w1", 0, 0, 0);
        run_windows(1, 4'b0001);
        exp_phase_q.push_back(2'd2);
        exp_sel = 2'd2;
        check_status("acq_w2", 2, 0, 0);
        run_windows(3, 4'b0001);
        check_status("lock_w5", 2, 0, 0);
        run_windows(1, 4'b0001);
        check_status("lock_w6", 2, 1, 0);

        // Hysteresis: an interrupted candidate must restart its count.
        run_windows(1, 4'b0010);
        check_status("hyst_a", 2, 1, 0);
        run_windows(1, 4'b0001);
        check_status("hyst_b", 2, 1, 0);
        run_windows(1, 4'b0010);
        check_status("hyst_c", 2, 1, 0);
        run_windows(1, 4'b0001);

        // Loss of signal after two empty windows, cleared by the next edge window.
        run_windows(1, 4'b0000);
        check_status("los_w1", 2, 1, 0);
        run_windows(1, 4'b0000);
        check_status("los_w2", 2, 0, 1);
        run_windows(1, 4'b0001);
        check_status("los_clear", 2, 0, 0);

        // Tie between phases 1 and 3 resolves to 1, so the target is 3.
        run_windows(1, 4'b1010);
        check_status("tie_w1", 2, 0, 0);
        run_windows(1, 4'b1010);
        exp_phase_q.push_back(2'd3);
        exp_sel = 2'd3;
        check_status("tie_w2", 3, 0, 0);

        // Synchronous clear via enable in the middle of a window.
        repeat (10) drive(1'b1, 4'b0100);
        enable = 1'b0;
        drive(1'b0, 4'b0000);
        exp_sel = 2'd0;
        check_status("disable", 0, 0, 0);
        check("disable.data_valid", int'(data_valid), 0);
        enable = 1'b1;

        // Valid every third cycle: a window spans 64 valids; idle-cycle edges must be ignored.
        run_gapped(2 * WINDOW - 1, 4'b0010, 4'b0100);
        check_status("gap_pre", 0, 0, 0);
        run_gapped(1, 4'b0010, 4'b0100);
        exp_phase_q.push_back(2'd3);
        exp_sel = 2'd3;
        check_status("gap_switch", 3, 0, 0);

        // Asynchronous reset mid-cycle clears outputs without a clock edge.
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_status("async_rst", 0, 0, 0);
        check("async_rst.data_valid", int'(data_valid), 0);
        check("async_rst.phase_changed", int'(phase_changed), 0);
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_status("post_rst", 0, 0, 0);

        check("data_queue_drained", exp_data_q.size(), 0);
        check("phase_queue_drained", exp_phase_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
